// File: rtl/mont_pkg.sv
// Shared definitions for the parametrised radix-2 Montgomery multiplier:
// FSM encoding, addend-select encoding and the chunk-count helper.
package mont_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECOMP,
    ST_SEL,
    ST_ADD,
    ST_SHIFT,
    ST_FSUB,
    ST_DONE,
    ST_ERRDONE
  } state_t;

  // Encoded as {q, a[i]} so the select falls straight out of the loop bits.
  typedef enum logic [1:0] {
    ADD_ZERO = 2'b00,
    ADD_B    = 2'b01,
    ADD_M    = 2'b10,
    ADD_BM   = 2'b11
  } addend_t;

  // Number of W-bit chunks needed to cover the N+2-bit accumulator.
  function automatic int calc_k(input int n, input int w);
    return (n + 2 + w - 1) / w;
  endfunction

endpackage

// File: rtl/mont_chunk_adder.sv
// K-cycle ripple adder/subtractor: one W-bit chunk per cycle, LSB chunk first,
// carry registered between chunks. Subtract is op_a + ~op_b + 1.
module mont_chunk_adder #(
  parameter int W = 128,
  parameter int K = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           sub,
  input  logic [K*W-1:0] op_a,
  input  logic [K*W-1:0] op_b,
  output logic [K*W-1:0] sum,
  output logic           carry,
  output logic           chunk_done
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  logic [IW-1:0]  idx;
  logic           carry_q;
  logic [K*W-1:0] sum_q;
  logic [W-1:0]   a_c;
  logic [W-1:0]   b_c;
  logic [W-1:0]   s_c;
  logic           cin;
  logic           cout;
  int             base;

  // sum/carry include the chunk being computed this cycle, so the caller can
  // consume the complete result on the chunk_done cycle.
  always_comb begin
    base        = int'(idx) * W;
    a_c         = op_a[base +: W];
    b_c         = op_b[base +: W] ^ {W{sub}};
    cin         = (idx == '0) ? sub : carry_q;
    {cout, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{W{1'b0}}, cin};
    sum         = sum_q;
    sum[base +: W] = s_c;
    carry       = cout;
    chunk_done  = en && (idx == IW'(K - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else if (en) begin
      sum_q[base +: W] <= s_c;
      carry_q          <= cout;
      idx              <= chunk_done ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/montgomery_mul_param.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-N mod m, m odd, with all
// wide arithmetic time-multiplexed through one chunked adder.
module montgomery_mul_param
  import mont_pkg::*;
#(
  parameter int N = 512,
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done,
  output logic         err,
  output state_t       dbg_state
);

  localparam int K    = calc_k(N, W);
  localparam int KW   = K * W;
  localparam int IW   = $clog2(N + 1);
  localparam int IDXW = $clog2(N);

  // Handshake: start is sampled only in IDLE (abort wins if both high); busy
  // covers PRECOMP..FSUB; done pulses one cycle with result valid, err with it
  // for an even modulus; abort drops any operation without a done pulse.

  state_t         state, state_nx;
  logic [N-1:0]   a_q, b_q, m_q, result_q;
  logic [N:0]     bm_q;
  logic [N+1:0]   c_q;
  logic [IW-1:0]  i_q;
  addend_t        sel_q, sel_now;
  logic           a_bit, q_bit, last_iter;
  logic [KW-1:0]  addend, add_a, add_b, add_sum;
  logic           add_en, add_sub, add_carry, add_last;

  assign a_bit     = a_q[i_q[IDXW-1:0]];
  assign q_bit     = c_q[0] ^ (a_bit & b_q[0]);
  assign sel_now   = addend_t'({q_bit, a_bit});
  assign last_iter = (i_q == IW'(N - 1));

  always_comb begin
    addend = '0;
    case (sel_q)
      ADD_B:   addend[N-1:0] = b_q;
      ADD_M:   addend[N-1:0] = m_q;
      ADD_BM:  addend[N:0]   = bm_q;
      default: addend = '0;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    add_en  = 1'b0;
    case (state)
      ST_PRECOMP: begin
        add_a[N-1:0] = b_q;
        add_b[N-1:0] = m_q;
        add_en       = 1'b1;
      end
      ST_ADD: begin
        add_a[N+1:0] = c_q;
        add_b        = addend;
        add_en       = 1'b1;
      end
      ST_FSUB: begin
        add_a[N+1:0] = c_q;
        add_b[N-1:0] = m_q;
        add_sub      = 1'b1;
        add_en       = 1'b1;
      end
      default: add_en = 1'b0;
    endcase
  end

  mont_chunk_adder #(.W(W), .K(K)) u_adder (
    .clk        (clk),
    .rst        (rst),
    .clr        (abort),
    .en         (add_en),
    .sub        (add_sub),
    .op_a       (add_a),
    .op_b       (add_b),
    .sum        (add_sum),
    .carry      (add_carry),
    .chunk_done (add_last)
  );

  generate
    if (KW > N + 2) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^add_sum[KW-1:N+2];
    end
  endgenerate

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_nx = in_m[0] ? ST_PRECOMP : ST_ERRDONE;
      ST_PRECOMP: if (add_last) state_nx = ST_SEL;
      ST_SEL: begin
        if (sel_now != ADD_ZERO) state_nx = ST_ADD;
        else if (last_iter)      state_nx = ST_FSUB;
      end
      ST_ADD:     if (add_last) state_nx = ST_SHIFT;
      ST_SHIFT:   state_nx = last_iter ? ST_FSUB : ST_SEL;
      ST_FSUB:    if (add_last) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      ST_ERRDONE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
    busy = (state == ST_PRECOMP) || (state == ST_SEL) || (state == ST_ADD) ||
           (state == ST_SHIFT) || (state == ST_FSUB);
    done = (state == ST_DONE) || (state == ST_ERRDONE);
    err  = (state == ST_ERRDONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      bm_q     <= '0;
      c_q      <= '0;
      i_q      <= '0;
      sel_q    <= ADD_ZERO;
      result_q <= '0;
    end else begin
      state <= state_nx;
      if (!abort) begin
        case (state)
          ST_IDLE: if (start) begin
            a_q <= in_a;
            b_q <= in_b;
            m_q <= in_m;
            c_q <= '0;
            i_q <= '0;
            if (!in_m[0]) result_q <= '0;
          end
          ST_PRECOMP: if (add_last) bm_q <= add_sum[N:0];
          ST_SEL: begin
            sel_q <= sel_now;
            if (sel_now == ADD_ZERO) begin
              c_q <= c_q >> 1;
              i_q <= i_q + 1'b1;
            end
          end
          ST_ADD: if (add_last) c_q <= add_sum[N+1:0];
          ST_SHIFT: begin
            c_q <= c_q >> 1;
            i_q <= i_q + 1'b1;
          end
          // carry=1 means no borrow, i.e. C >= M and the difference is kept.
          ST_FSUB: if (add_last) result_q <= add_carry ? add_sum[N-1:0] : c_q[N-1:0];
          default: ;
        endcase
      end
    end
  end

  assign result    = result_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_montgomery_mul_param.sv
// Scoreboard bench for montgomery_mul_param: an N=8/W=4 instance for directed
// and reference-model vectors, and an N=512/W=128 instance for abort.
module tb_montgomery_mul_param;
  import mont_pkg::*;

  localparam int N8 = 8;
  localparam int W8 = 4;
  localparam int NL = 512;
  localparam int WL = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  logic          start8, abort8, busy8, done8, err8;
  logic [N8-1:0] a8, b8, m8, res8;
  state_t        st8;
  logic          startL, abortL, busyL, doneL, errL;
  logic [NL-1:0] aL, bL, mL, resL;
  state_t        stL;

  montgomery_mul_param #(.N(N8), .W(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8),
    .in_a(a8), .in_b(b8), .in_m(m8),
    .result(res8), .busy(busy8), .done(done8), .err(err8), .dbg_state(st8)
  );

  montgomery_mul_param #(.N(NL), .W(WL)) dutL (
    .clk(clk), .rst(rst), .start(startL), .abort(abortL),
    .in_a(aL), .in_b(bL), .in_m(mL),
    .result(resL), .busy(busyL), .done(doneL), .err(errL), .dbg_state(stL)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [N8:0] exp_q8[$];
  logic [NL:0] exp_qL[$];
  logic [N8:0] e8;
  logic [NL:0] eL;

  task automatic chk(input string name, input logic [NL-1:0] act, input logic [NL-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done8 === 1'b1) begin
      if (exp_q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut8_unexpected_done: got done=1 expected no completion");
      end else begin
        e8 = exp_q8.pop_front();
        chk("dut8_result", res8, e8[N8-1:0]);
        chk("dut8_err", err8, e8[N8]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && doneL === 1'b1) begin
      if (exp_qL.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dutL_unexpected_done: got done=1 expected no completion");
      end else begin
        eL = exp_qL.pop_front();
        chk("dutL_result", resL, eL[NL-1:0]);
        chk("dutL_err", errL, eL[NL]);
      end
    end
  end

  // Reference: reduce a*b mod m, then divide by 2 mod m n times.
  function automatic logic [NL-1:0] mont_ref(input logic [NL-1:0] a, input logic [NL-1:0] b,
                                             input logic [NL-1:0] m, input int n);
    logic [2*NL+1:0] aa, bb, mm, x;
    aa = a;
    bb = b;
    mm = m;
    x  = (aa * bb) % mm;
    for (int k = 0; k < n; k++) begin
      if (x[0]) x = x + mm;
      x = x >> 1;
    end
    return x[NL-1:0];
  endfunction

  function automatic logic [NL-1:0] rand512();
    logic [NL-1:0] r;
    r = '0;
    for (int k = 0; k < NL / 32; k++) r = {r[NL-33:0], 32'($urandom())};
    return r;
  endfunction

  // ---------------- drivers ----------------
  // Latency counts the start cycle as cycle 1 and includes the done cycle.
  task automatic op8(input logic [N8-1:0] a, input logic [N8-1:0] b, input logic [N8-1:0] m,
                     input logic [N8-1:0] exp_res, input logic exp_err, input int exp_lat);
    int lat, busy_bad;
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
    exp_q8.push_back({exp_err, exp_res});
    @(negedge clk);
    start8 = 1'b0;
    lat = 2;
    busy_bad = 0;
    while (done8 !== 1'b1 && lat < 200) begin
      if (busy8 !== !exp_err) busy_bad++;
      @(negedge clk);
      lat++;
    end
    chk("dut8_done_seen", done8, 1);
    chk("dut8_busy_window", busy_bad, 0);
    chk("dut8_busy_at_done", busy8, 0);
    if (exp_lat > 0) chk("dut8_latency", lat, exp_lat);
    else chk("dut8_latency_range", (lat >= 16 && lat <= 48), 1);
  endtask

  task automatic opL(input logic [NL-1:0] a, input logic [NL-1:0] b, input logic [NL-1:0] m,
                     input logic [NL-1:0] exp_res);
    int lat;
    @(negedge clk);
    aL = a; bL = b; mL = m; startL = 1'b1;
    exp_qL.push_back({1'b0, exp_res});
    @(negedge clk);
    startL = 1'b0;
    lat = 2;
    while (doneL !== 1'b1 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    chk("dutL_done_seen", doneL, 1);
    chk("dutL_latency_range", (lat >= 524 && lat <= 3596), 1);
  endtask

  task automatic rand_vec(output logic [NL-1:0] a, output logic [NL-1:0] b,
                          output logic [NL-1:0] m);
    m = rand512();
    m[NL-1] = 1'b1;
    m[0] = 1'b1;
    a = (rand512() % (m - 1)) | 1;
    b = rand512() % m;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N8-1:0] ra, rb, rm;
    logic [NL-1:0] la, lb, lm, lexp;
    int cnt;

    rst = 1'b1;
    start8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    startL = 1'b0; abortL = 1'b0; aL = '0; bL = '0; mL = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", res8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_err", err8, 0);
    chk("rst_state", st8, ST_IDLE);
    chk("rst_result_L", resL, 0);
    rst = 1'b0;

    // Directed vectors (hand computed: 2^-8 mod 13 = 3)
    op8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 0);
    op8(8'd12, 8'd12, 8'd13, 8'd3, 1'b0, 0);
    op8(8'd0, 8'd9, 8'd13, 8'd0, 1'b0, 16);
    op8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 0);
    op8(8'd5, 8'd5, 8'd12, 8'd0, 1'b1, 2);

    // Random odd moduli against the reference model
    for (int t = 0; t < 150; t++) begin
      rm = 8'(2 * $urandom_range(1, 127) + 1);
      ra = 8'($urandom_range(0, int'(rm) - 1));
      rb = 8'($urandom_range(0, int'(rm) - 1));
      op8(ra, rb, rm, mont_ref(NL'(ra), NL'(rb), NL'(rm), N8), 1'b0, 0);
    end

    // start while busy is ignored; input changes after capture have no effect
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
    exp_q8.push_back({1'b0, 8'd1});
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    a8 = 8'd12; b8 = 8'd12; m8 = 8'd12; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cnt = 0;
    while (done8 !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("busy_start_done_seen", done8, 1);
    repeat (60) @(negedge clk);

    // start together with abort in IDLE: nothing accepted
    start8 = 1'b1; abort8 = 1'b1; a8 = 8'd5; b8 = 8'd7; m8 = 8'd13;
    @(negedge clk);
    start8 = 1'b0; abort8 = 1'b0;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (busy8 !== 1'b0 || done8 !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("start_abort_ignored", cnt, 0);
    chk("start_abort_result_held", res8, 1);

    // rst pulsed during FSUB (a=0: FSUB occupies cycles 13..15)
    a8 = 8'd0; b8 = 8'd9; m8 = 8'd13; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_state_fsub", st8, ST_FSUB);
    chk("pre_rst_result_held", res8, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_result", res8, 0);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_state", st8, ST_IDLE);
    rst = 1'b0;
    op8(8'd12, 8'd12, 8'd13, 8'd3, 1'b0, 0);

    // Wide instance: full op, abort mid-ADD, then a fresh op
    rand_vec(la, lb, lm);
    lexp = mont_ref(la, lb, lm, NL);
    opL(la, lb, lm, lexp);

    rand_vec(la, lb, lm);
    @(negedge clk);
    aL = la; bL = lb; mL = lm; startL = 1'b1;
    @(negedge clk);
    startL = 1'b0;
    cnt = 0;
    while (stL !== ST_ADD && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("dutL_reached_add", stL, ST_ADD);
    abortL = 1'b1;
    @(negedge clk);
    abortL = 1'b0;
    chk("dutL_abort_state", stL, ST_IDLE);
    chk("dutL_abort_busy", busyL, 0);
    chk("dutL_abort_result_held", resL, lexp);
    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (busyL !== 1'b0 || doneL !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("dutL_abort_quiet", cnt, 0);

    rand_vec(la, lb, lm);
    opL(la, lb, lm, mont_ref(la, lb, lm, NL));

    repeat (5) @(negedge clk);
    chk("dut8_queue_empty", exp_q8.size(), 0);
    chk("dutL_queue_empty", exp_qL.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
